// File: rtl/execute_stage.sv
// Execute stage of a 5-stage RV32 pipeline: forwarding, ALU, branch/jump resolve, EX/MEM register.
// Latency: PCSrcE/PCTargetE combinational in the same cycle; all M outputs 1 cycle (EX/MEM register).
// Backpressure: none; the EX/MEM register loads on every clock, and flushes arrive as zero-control bubbles.
//
// Ports:
//   clk, rst                      - clock (rising edge), asynchronous active-high reset
//   RD1E, RD2E, PCE, PCPlus4E,    - ID/EX datapath values
//   ImmExtE, RdE
//   RegWriteE, MemWriteE, JumpE,  - ID/EX control
//   BranchE, ALUSrcE, ResultSrcE,
//   ALUControlE, LoadByteE
//   ResultW, ForwardAE, ForwardBE - writeback forward source and hazard-unit selects
//   PCSrcE, PCTargetE             - combinational redirect request and target
//   *M                            - EX/MEM pipeline register outputs
module execute_stage #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] RD1E,
  input  logic [WORD_SIZE-1:0] RD2E,
  input  logic [WORD_SIZE-1:0] PCE,
  input  logic [WORD_SIZE-1:0] PCPlus4E,
  input  logic [WORD_SIZE-1:0] ImmExtE,
  input  logic [4:0]           RdE,
  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 JumpE,
  input  logic                 BranchE,
  input  logic                 ALUSrcE,
  input  logic [1:0]           ResultSrcE,
  input  logic [2:0]           ALUControlE,
  input  logic                 LoadByteE,
  input  logic [WORD_SIZE-1:0] ResultW,
  input  logic [1:0]           ForwardAE,
  input  logic [1:0]           ForwardBE,
  output logic                 PCSrcE,
  output logic [WORD_SIZE-1:0] PCTargetE,
  output logic [WORD_SIZE-1:0] ALUResultM,
  output logic [WORD_SIZE-1:0] WriteDataM,
  output logic [4:0]           RdM,
  output logic [WORD_SIZE-1:0] PCPlus4M,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic [1:0]           ResultSrcM,
  output logic                 LoadByteM
);

  logic [WORD_SIZE-1:0] srcA;
  logic [WORD_SIZE-1:0] fwdB;
  logic [WORD_SIZE-1:0] srcB;
  logic [WORD_SIZE-1:0] aluResult;
  logic                 zeroE;

  // Forwarding: 10 takes our own registered ALU result (EX/MEM -> EX path);
  // the unused encoding 11 falls back to the register-file value.
  always_comb begin
    srcA = RD1E;
    case (ForwardAE)
      2'b01:   srcA = ResultW;
      2'b10:   srcA = ALUResultM;
      default: srcA = RD1E;
    endcase
  end

  always_comb begin
    fwdB = RD2E;
    case (ForwardBE)
      2'b01:   fwdB = ResultW;
      2'b10:   fwdB = ALUResultM;
      default: fwdB = RD2E;
    endcase
  end

  // Store data must be the forwarded rs2, taken before the immediate mux.
  assign srcB = ALUSrcE ? ImmExtE : fwdB;

  always_comb begin
    aluResult = '0;
    case (ALUControlE)
      3'b000:  aluResult = srcA + srcB;
      3'b001:  aluResult = srcA - srcB;
      3'b010:  aluResult = srcA & srcB;
      3'b011:  aluResult = srcA | srcB;
      3'b100:  aluResult = srcA ^ srcB;
      3'b101:  aluResult = {{(WORD_SIZE-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      3'b110:  aluResult = srcA << srcB[4:0];
      3'b111:  aluResult = srcA >> srcB[4:0];
      default: aluResult = '0;
    endcase
  end

  assign zeroE     = (aluResult == '0);
  assign PCSrcE    = JumpE | (BranchE & zeroE);
  assign PCTargetE = PCE + ImmExtE;

  // EX/MEM register: no enable; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      LoadByteM  <= 1'b0;
    end else begin
      ALUResultM <= aluResult;
      WriteDataM <= fwdB;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      LoadByteM  <= LoadByteE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed vectors with literal expectations plus a
// behavioural model compared against the DUT on every falling clock edge.
// Inputs change 2 time units after a rising edge; outputs sampled away from that edge.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, ResultW;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, LoadByteE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic        PCSrcE;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM, LoadByteM;
  logic [1:0]  ResultSrcM;

  int nChecks = 0;
  int nFails  = 0;

  execute_stage #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .LoadByteE(LoadByteE), .ResultW(ResultW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .LoadByteM(LoadByteM)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mAlu, mWd, mPc4;
  logic [4:0]  mRd;
  logic        mRw, mMw, mLb;
  logic [1:0]  mRs;

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] aluOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  function automatic logic [31:0] modelAlu();
    logic [31:0] a, b;
    a = pick(ForwardAE, RD1E, ResultW, mAlu);
    b = ALUSrcE ? ImmExtE : pick(ForwardBE, RD2E, ResultW, mAlu);
    return aluOp(ALUControlE, a, b);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mAlu <= 0; mWd <= 0; mPc4 <= 0; mRd <= 0;
      mRw <= 0; mMw <= 0; mLb <= 0; mRs <= 0;
    end else begin
      mAlu <= modelAlu();
      mWd  <= pick(ForwardBE, RD2E, ResultW, mAlu);
      mPc4 <= PCPlus4E;
      mRd  <= RdE;
      mRw  <= RegWriteE;
      mMw  <= MemWriteE;
      mLb  <= LoadByteE;
      mRs  <= ResultSrcE;
    end
  end

  // Compare process: every falling edge, registered and combinational outputs.
  always @(negedge clk) begin
    check("m_ALUResultM", ALUResultM, mAlu);
    check("m_WriteDataM", WriteDataM, mWd);
    check("m_PCPlus4M", PCPlus4M, mPc4);
    check("m_RdM", {27'd0, RdM}, {27'd0, mRd});
    check("m_RegWriteM", {31'd0, RegWriteM}, {31'd0, mRw});
    check("m_MemWriteM", {31'd0, MemWriteM}, {31'd0, mMw});
    check("m_LoadByteM", {31'd0, LoadByteM}, {31'd0, mLb});
    check("m_ResultSrcM", {30'd0, ResultSrcM}, {30'd0, mRs});
    check("m_PCTargetE", PCTargetE, PCE + ImmExtE);
    check("m_PCSrcE", {31'd0, PCSrcE}, {31'd0, JumpE | (BranchE & (modelAlu() == 0))});
  end

  // ---------------- directed stimulus ----------------
  task automatic clrE();
    RD1E = 0; RD2E = 0; PCE = 0; PCPlus4E = 0; ImmExtE = 0; ResultW = 0; RdE = 0;
    RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0; LoadByteE = 0;
    ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0; ALUControlE = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_alu"}, ALUResultM, 32'd0);
    check({tag, "_wd"}, WriteDataM, 32'd0);
    check({tag, "_pc4"}, PCPlus4M, 32'd0);
    check({tag, "_ctl"}, {18'd0, RdM, RegWriteM, MemWriteM, ResultSrcM, LoadByteM, 5'd0}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    clrE();
    #1;
    checkAllZero("reset");
    step();
    rst = 1'b0;

    // add 5 + 7 -> x3
    RD1E = 5; RD2E = 7; RegWriteE = 1; RdE = 3; PCPlus4E = 32'h44; ResultSrcE = 2'd1;
    #1 check("add_pcsrc", {31'd0, PCSrcE}, 32'd0);
    step();
    check("add_alu", ALUResultM, 32'd12);
    check("add_rd", {27'd0, RdM}, 32'd3);
    check("add_rw", {31'd0, RegWriteM}, 32'd1);
    check("add_pc4", PCPlus4M, 32'h44);

    // forwarding: A from ALUResultM (12), B store data from ResultW
    clrE();
    ForwardAE = 2'b10; ALUSrcE = 1; ImmExtE = 4; ForwardBE = 2'b01; ResultW = 32'hAA;
    MemWriteE = 1; LoadByteE = 1;
    step();
    check("fwd_alu", ALUResultM, 32'd16);
    check("fwd_wd", WriteDataM, 32'hAA);
    check("fwd_mw", {31'd0, MemWriteM}, 32'd1);
    check("fwd_lb", {31'd0, LoadByteM}, 32'd1);

    // branch resolve, combinational
    clrE();
    BranchE = 1; ALUControlE = 3'b001; RD1E = 9; RD2E = 9; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
    #1 check("beq_taken", {31'd0, PCSrcE}, 32'd1);
    check("beq_target", PCTargetE, 32'h0000_00F8);
    RD2E = 8;
    #1 check("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    JumpE = 1;
    #1 check("jal_taken", {31'd0, PCSrcE}, 32'd1);
    step();

    // ALU edge cases
    clrE(); ALUControlE = 3'd5; RD1E = 32'hFFFF_FFFF; RD2E = 1;
    step(); check("slt_signed", ALUResultM, 32'd1);
    clrE(); ALUControlE = 3'd0; RD1E = 32'hFFFF_FFFF; RD2E = 1;
    step(); check("add_wrap", ALUResultM, 32'd0);
    clrE(); ALUControlE = 3'd6; RD1E = 1; ALUSrcE = 1; ImmExtE = 32'h21;
    step(); check("sll_5bit", ALUResultM, 32'd2);
    clrE(); ALUControlE = 3'd7; RD1E = 32'h8000_0000; RD2E = 31;
    step(); check("srl_31", ALUResultM, 32'd1);
    clrE(); ALUControlE = 3'd4; RD1E = 32'hF0F0_1234; RD2E = 32'h0FF0_1234;
    step(); check("xor", ALUResultM, 32'hFF00_0000);
    clrE(); ForwardAE = 2'b11; ForwardBE = 2'b11; RD1E = 32'h55; ResultW = 32'h1000; RD2E = 32'h3;
    RdE = 5'd31; RegWriteE = 1; PCPlus4E = 32'h1234; ResultSrcE = 2'd2;
    step(); check("fwd11_rd1", ALUResultM, 32'h58);
    check("fwd11_wd", WriteDataM, 32'h3);

    // bubble: all-zero controls
    clrE();
    step();
    check("bubble_rw", {31'd0, RegWriteM}, 32'd0);
    check("bubble_mw", {31'd0, MemWriteM}, 32'd0);

    // reset between edges, with nonzero outputs loaded first
    RD1E = 32'h77; RD2E = 32'h66; RdE = 5'd9; RegWriteE = 1; MemWriteE = 1; PCPlus4E = 32'h88;
    ResultSrcE = 2'd3; LoadByteE = 1;
    step();
    check("pre_rst_alu", ALUResultM, 32'hDD);
    #2 rst = 1'b1;
    #1 checkAllZero("rst_async");
    step(); checkAllZero("rst_hold1");
    step(); checkAllZero("rst_hold2");
    clrE(); RD1E = 20; RD2E = 22; RdE = 7; RegWriteE = 1;
    rst = 1'b0;
    step();
    check("post_rst_alu", ALUResultM, 32'd42);
    check("post_rst_rd", {27'd0, RdM}, 32'd7);

    clrE();
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
